assoc_layer_learner: RTL

ASSOC_LAYER_LEARNER -- requirements
Module: assoc_layer_learner

---
 rtl/assoc_layer_learner_pkg.sv | 28 ++
 rtl/assoc_layer_learner_controller.sv | 78 +++++++
 rtl/assoc_layer_learner.sv | 119 +++++++++++
 3 files changed

// File: rtl/assoc_layer_learner_pkg.sv
// -----------------------------------------------------------------------------
// GAM_package
// Shared types and constants for the association layer of the GAM network.
//   GAM_MAX_NODES  : number of memory-layer nodes tracked
//   node_idx_T     : node index, one bit wider than needed so that indices at
//                    or beyond GAM_MAX_NODES can be seen and flagged
//   class_T        : class label
//   assoc_weight_T : association weight (default width)
//   assoc_state_T  : learner FSM states
// -----------------------------------------------------------------------------
package GAM_package;

   localparam int GAM_MAX_NODES = 32;
   localparam int NODE_IDX_W    = $clog2(GAM_MAX_NODES) + 1;

   typedef logic [NODE_IDX_W-1:0] node_idx_T;
   typedef logic [7:0]            class_T;
   typedef logic [7:0]            assoc_weight_T;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      READ,
      UPDATE,
      DONE
   } assoc_state_T;

endpackage

// File: rtl/assoc_layer_learner_controller.sv
// -----------------------------------------------------------------------------
// assoc_layer_controller
// Sequencing FSM for the association learner. One state per cycle.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   start              : learning request (honoured only in IDLE)
//   cur_in_range       : latched winner index is below GAM_MAX_NODES
//   prev_valid         : a previous node exists in the current sequence
//   state              : current FSM state, drives the inline datapath
//   done               : one-cycle pulse, high while in DONE
//   busy               : high whenever the FSM is not in IDLE
//   err_range          : sticky out-of-range flag, cleared only by reset
// -----------------------------------------------------------------------------
module assoc_layer_controller
   import GAM_package::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         cur_in_range,
   input  logic         prev_valid,
   output assoc_state_T state,
   output logic         done,
   output logic         busy,
   output logic         err_range
);

   // Outputs are registered alongside the state so they track it exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         busy      <= 1'b0;
         err_range <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= CAPTURE;
                  busy  <= 1'b1;
               end
            end
            CAPTURE: begin
               if (!cur_in_range) begin
                  err_range <= 1'b1;
                  state     <= DONE;
                  done      <= 1'b1;
               end else begin
                  state <= READ;
               end
            end
            READ: begin
               if (prev_valid) begin
                  state <= UPDATE;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            UPDATE: begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/assoc_layer_learner.sv
// -----------------------------------------------------------------------------
// assoc_layer_learner
// Learns first-order transitions between memory-layer winner nodes: for each
// consecutive pair (prev -> cur) inside a sequence, weight[prev][cur] is
// incremented with saturation. The class label of each node is recorded.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   assoc_learning_start  : new sample valid this cycle (accepted in IDLE only)
//   winner_node, class_in : sample node index and class label
//   seq_clear             : end of sequence, forgets the previous node
//   rd_src, rd_dst        : query indices
//   rd_weight, rd_class   : weight[rd_src][rd_dst] and class_tbl[rd_dst],
//                           registered, one-cycle latency
//   assoc_learning_done   : one-cycle pulse ending each accepted request
//   busy                  : FSM not in IDLE
//   err_range             : sticky, winner_node >= GAM_MAX_NODES seen
// -----------------------------------------------------------------------------
module assoc_layer_learner
   import GAM_package::*;
#(
   parameter int GAM_MAX_NODES = GAM_package::GAM_MAX_NODES,
   parameter int ASSOC_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               assoc_learning_start,
   input  node_idx_T          winner_node,
   input  class_T             class_in,
   input  logic               seq_clear,
   input  node_idx_T          rd_src,
   input  node_idx_T          rd_dst,
   output logic [ASSOC_W-1:0] rd_weight,
   output class_T             rd_class,
   output logic               assoc_learning_done,
   output logic               busy,
   output logic               err_range
);

   localparam int        AW      = $clog2(GAM_MAX_NODES);
   localparam node_idx_T MAX_IDX = node_idx_T'(GAM_MAX_NODES);

   function automatic logic [ASSOC_W-1:0] sat_inc(input logic [ASSOC_W-1:0] w);
      return (&w) ? w : w + 1'b1;
   endfunction

   assoc_state_T       state;
   node_idx_T          cur_node;
   class_T             cur_class;
   logic [AW-1:0]      prev_node;
   logic               prev_valid;
   logic [ASSOC_W-1:0] wt_fetch_p1;
   logic               cur_in_range;
   logic               rd_in_range;

   logic [ASSOC_W-1:0] weight    [GAM_MAX_NODES][GAM_MAX_NODES];
   class_T             class_tbl [GAM_MAX_NODES];

   assign cur_in_range = (cur_node < MAX_IDX);
   assign rd_in_range  = (rd_src < MAX_IDX) && (rd_dst < MAX_IDX);

   assoc_layer_controller u_ctrl (
      .clk          (clk),
      .reset        (reset),
      .start        (assoc_learning_start),
      .cur_in_range (cur_in_range),
      .prev_valid   (prev_valid),
      .state        (state),
      .done         (assoc_learning_done),
      .busy         (busy),
      .err_range    (err_range)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < GAM_MAX_NODES; i++) begin
            class_tbl[i] <= '0;
            for (int j = 0; j < GAM_MAX_NODES; j++) begin
               weight[i][j] <= '0;
            end
         end
         cur_node    <= '0;
         cur_class   <= '0;
         prev_node   <= '0;
         prev_valid  <= 1'b0;
         wt_fetch_p1 <= '0;
         rd_weight   <= '0;
         rd_class    <= '0;
      end else begin
         if (state == IDLE && assoc_learning_start) begin
            cur_node  <= winner_node;
            cur_class <= class_in;
         end
         if (state == CAPTURE && cur_in_range) begin
            class_tbl[cur_node[AW-1:0]] <= cur_class;
         end
         // p1: fetch the pair weight one cycle ahead of the write-back
         if (state == READ) begin
            wt_fetch_p1 <= weight[prev_node][cur_node[AW-1:0]];
         end
         if (state == UPDATE) begin
            weight[prev_node][cur_node[AW-1:0]] <= sat_inc(wt_fetch_p1);
         end
         // Leaving the sample path makes this node the previous one; a
         // simultaneous seq_clear still wins so the sequence really ends.
         if ((state == READ && !prev_valid) || state == UPDATE) begin
            prev_node <= cur_node[AW-1:0];
         end
         if (seq_clear) begin
            prev_valid <= 1'b0;
         end else if ((state == READ && !prev_valid) || state == UPDATE) begin
            prev_valid <= 1'b1;
         end
         // Registered query port: a same-cycle write is seen on the next read.
         rd_weight <= rd_in_range ? weight[rd_src[AW-1:0]][rd_dst[AW-1:0]] : '0;
         rd_class  <= (rd_dst < MAX_IDX) ? class_tbl[rd_dst[AW-1:0]] : '0;
      end
   end

endmodule
